// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - clocked WIDTH-bit ALU with multi-cycle unsigned multiply/divide
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] HI,
    output logic             Z,
    output logic             O,
    output logic             DIVZ,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MULU = 4'b0011;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIVI} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] r_q, hi_q;
    logic             z_q, o_q, divz_q, busy_q, done_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;

    logic [WIDTH-1:0] a_x, b_x, alu_r;
    logic [WIDTH:0]   sum;
    logic             c_msb, ovf, alu_o;

    // Bit 3 inverts A, bit 2 inverts B and supplies the carry-in.
    always_comb begin
        a_x   = OP[3] ? ~A : A;
        b_x   = OP[2] ? ~B : B;
        sum   = {1'b0, a_x} + {1'b0, b_x} + {{WIDTH{1'b0}}, OP[2]};
        c_msb = sum[WIDTH-1] ^ a_x[WIDTH-1] ^ b_x[WIDTH-1];
        ovf   = c_msb ^ sum[WIDTH];
        alu_r = '0;
        alu_o = 1'b0;
        case (OP)
            OP_AND, OP_NOR: alu_r = a_x & b_x;
            OP_OR, OP_NAND: alu_r = a_x | b_x;
            OP_ADD, OP_SUB: begin
                alu_r = sum[WIDTH-1:0];
                alu_o = ovf;
            end
            OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            default: alu_r = '0;
        endcase
    end

    logic [WIDTH:0]   mul_sum, rem_sh, diff;
    logic [WIDTH-1:0] mul_hi_d, mul_lo_d, div_hi_d, div_lo_d;
    logic             qbit;

    // Multiply: acc_lo holds the multiplier, shifted out LSB first as the product shifts in.
    // Divide: acc_lo holds the dividend, shifted out MSB first as quotient bits shift in.
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_d = mul_sum[WIDTH:1];
        mul_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, opnd_q};
        qbit     = ~diff[WIDTH];
        div_hi_d = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_lo_d = {acc_lo_q[WIDTH-2:0], qbit};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            r_q      <= '0;
            hi_q     <= '0;
            z_q      <= 1'b1;
            o_q      <= 1'b0;
            divz_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        if (OP == OP_MULU || (OP == OP_DIVU && B != '0)) begin
                            acc_hi_q <= '0;
                            acc_lo_q <= (OP == OP_MULU) ? B : A;
                            opnd_q   <= (OP == OP_MULU) ? A : B;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= (OP == OP_MULU) ? S_MULT : S_DIVI;
                        end else if (OP == OP_DIVU) begin
                            r_q    <= '1;
                            hi_q   <= A;
                            z_q    <= 1'b0;
                            o_q    <= 1'b0;
                            divz_q <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            r_q    <= alu_r;
                            hi_q   <= '0;
                            z_q    <= (alu_r == '0);
                            o_q    <= alu_o;
                            divz_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_MULT, S_DIVI: begin
                    acc_hi_q <= (state_q == S_MULT) ? mul_hi_d : div_hi_d;
                    acc_lo_q <= (state_q == S_MULT) ? mul_lo_d : div_lo_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        r_q     <= (state_q == S_MULT) ? mul_lo_d : div_lo_d;
                        hi_q    <= (state_q == S_MULT) ? mul_hi_d : div_hi_d;
                        z_q     <= (((state_q == S_MULT) ? mul_lo_d : div_lo_d) == '0);
                        o_q     <= 1'b0;
                        divz_q  <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign R    = r_q;
    assign HI   = hi_q;
    assign Z    = z_q;
    assign O    = o_q;
    assign DIVZ = divz_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule
